bpm_control: RTL and testbench
==============================

// Module: bpm_control
// PURPOSE
// - Upstream tempo/transport stage. Produces BPM[7:0] and PLAY for the 4-digit 7-seg display stage.
// - Produces BEAT, a one-cycle pulse at the selected tempo, for the note sequencer.
// - Inputs are three raw push-buttons: tempo up, tempo down, play/pause.
// PARAMETERS
// - TICK_DIV     100000  CLK cycles per 1 ms tick (100 MHz CLK)
// - DEBOUNCE_MS  10      consecutive equal 1 ms samples before a button state is accepted
// - BPM_MIN      30      lower saturation limit for BPM
// - BPM_MAX      240     upper saturation limit for BPM
// - BPM_INIT     120     BPM value after reset
// - RPT_DELAY_MS 500     hold time before auto-repeat starts (AUTO_REPEAT_EN only)
// - RPT_RATE_MS  100     auto-repeat step interval (AUTO_REPEAT_EN only)
// PORTS
// - CLK       in   1  100 MHz system clock; all logic on posedge
// - RST_N     in   1  synchronous, active-low reset
// - BTN_UP    in   1  raw tempo-up button, asynchronous, active-high
// - BTN_DOWN  in   1  raw tempo-down button, asynchronous, active-high
// - BTN_PLAY  in   1  raw play/pause button, asynchronous, active-high
// - BPM       out  8  current tempo, unsigned binary, always in BPM_MIN..BPM_MAX
// - PLAY      out  1  1 = playing, 0 = paused
// - BEAT      out  1  one-CLK pulse per beat; only asserted while PLAY=1
// BEHAVIOUR
// - Reset (RST_N=0 at a posedge): BPM=BPM_INIT, PLAY=0, BEAT=0.
//   Also cleared: tick counter, accumulator, debounced states, sync flops.
// - Sync: each button passes through a 2-FF synchroniser before any other use.
// - Tick: counter runs 0..TICK_DIV-1. TICK pulses for one cycle when the count equals TICK_DIV-1, then wraps to 0.
// - Debounce: per button, the synced level is sampled on TICK.
//   - Debounced state flips after DEBOUNCE_MS consecutive samples that differ from the current state.
//   - Any agreeing sample resets that count.
// - Press event: debounced 0->1 transition, one-cycle pulse. Release produces no event.
// - Tempo: press_up -> BPM+1; press_down -> BPM-1.
//   - Saturates at BPM_MAX and BPM_MIN; no wrap.
//   - press_up and press_down in the same cycle -> BPM unchanged.
//   - BPM register updates the cycle after the event.
// - Transport: press_play toggles PLAY, registered the cycle after the event.
// - Beat accumulator ACC, 16 bits:
//   - PLAY=0: ACC held at 0, BEAT=0.
//   - Cycle PLAY goes 0->1: BEAT=1 (downbeat), ACC=0.
//   - PLAY=1 and TICK: SUM=ACC+BPM (17-bit compare).
//     - SUM>=60000 -> ACC=SUM-60000 and BEAT=1 for that cycle.
//     - Otherwise ACC=SUM.
//   - Mean beat period is exactly 60000/BPM ms.
//   - A BPM change takes effect at the next TICK; ACC is not cleared.
//   - PLAY 1->0 in the same cycle as a beat: BEAT suppressed, ACC cleared.
// - Reset mid-beat or mid-debounce: everything returns to reset values; no residual events.
// CONFIGURATION
// - Macro AUTO_REPEAT_EN.
// - Defined: a debounced-held UP or DOWN (but not both) generates its first step on press.
//   - After RPT_DELAY_MS further ms held, it steps again every RPT_RATE_MS ms, same saturation rules.
//   - The repeat timer resets on release.
// - Undefined: exactly one step per press; hold time is ignored; repeat logic is not compiled.
// TESTING (bench overrides TICK_DIV=10, DEBOUNCE_MS=3, RPT_DELAY_MS=20, RPT_RATE_MS=5)
// - Reset: RST_N low 5 cycles -> BPM=120, PLAY=0, BEAT=0. Repeat with RST_N asserted mid-press -> same values, no step.
// - Single press: BTN_UP high 10 ticks -> BPM=121 exactly once.
//   - Then BTN_DOWN high 10 ticks -> BPM=120.
// - Bounce: BTN_UP toggling each tick for 8 ticks then low -> BPM stays 120.
//   - Up and down pressed together -> BPM stays 120.
// - Saturation: 130 up presses -> BPM=240. 220 down presses -> BPM=30.
// - Beat timing: press play at BPM=120 -> BEAT on the PLAY rise, then every 500 ticks (5000 CLK).
//   - At BPM=240: every 250 ticks.
//   - Second play press -> PLAY=0, no further BEAT.
// - AUTO_REPEAT_EN: hold BTN_UP 50 ticks from BPM=120 -> steps at press, +20, +25, +30 ... -> BPM=127.
//   - Without the macro: BPM=121.

Source files
------------

// File: rtl/bpm_control.sv
// Tempo/transport front end: debounced buttons set BPM and PLAY, and a 60000-modulus
// accumulator on the 1 ms tick emits BEAT. Define AUTO_REPEAT_EN for held-button auto-repeat.
module bpm_control #(
  parameter int TICK_DIV     = 100000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int BPM_MIN      = 30,
  parameter int BPM_MAX      = 240,
  parameter int BPM_INIT     = 120,
  parameter int RPT_DELAY_MS = 500,
  parameter int RPT_RATE_MS  = 100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_PLAY,
  output logic [7:0] BPM,
  output logic       PLAY,
  output logic       BEAT
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int B_UP   = 0;
  localparam int B_DN   = 1;
  localparam int B_PL   = 2;
  localparam logic [16:0] ACC_WRAP = 17'd60000;

  if (TICK_DIV < 2 || DEBOUNCE_MS < 1 || BPM_MIN < 1 || BPM_MAX > 255 ||
      BPM_MIN >= BPM_MAX || BPM_INIT < BPM_MIN || BPM_INIT > BPM_MAX ||
      RPT_DELAY_MS < 1 || RPT_RATE_MS < 1) begin : g_bad_cfg
    $error("bpm_control: inconsistent parameter set");
  end

  logic [2:0] btn_raw;
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] db_state;
  logic [2:0] db_prev;
  logic [2:0] press;
  logic [DB_W-1:0] db_cnt [3];
  logic [TICK_W-1:0] tick_cnt;
  logic tick;

  assign btn_raw = {BTN_PLAY, BTN_DOWN, BTN_UP};

  // NOTE: non-blocking assignments let sync_b take the old sync_a, forming a real 2-FF chain.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // NOTE: the per-button counters are only three small registers, so they are reset like any flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      db_state <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db_state;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          if (sync_b[i] == db_state[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DB_W'(DEBOUNCE_MS - 1)) begin
            db_state[i] <= ~db_state[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign press = db_state & ~db_prev;

  logic step_up;
  logic step_dn;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY_MS > RPT_RATE_MS) ? RPT_DELAY_MS : RPT_RATE_MS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             tick_q;
  logic             rpt_active;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_limit;
  logic             held_one;
  logic             rpt_fire;

  // Timer advances the cycle after TICK so it sees the debounced state that TICK produced;
  // a release landing on a repeat boundary therefore suppresses that step.
  assign held_one  = db_state[B_UP] ^ db_state[B_DN];
  assign rpt_limit = rpt_active ? RPT_W'(RPT_RATE_MS - 1) : RPT_W'(RPT_DELAY_MS - 1);
  assign rpt_fire  = held_one && !(|press[1:0]) && tick_q && (rpt_cnt == rpt_limit);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tick_q     <= 1'b0;
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
    end else begin
      tick_q <= tick;
      if (!held_one || (|press[1:0])) begin
        rpt_cnt    <= '0;
        rpt_active <= 1'b0;
      end else if (tick_q) begin
        if (rpt_fire) begin
          rpt_cnt    <= '0;
          rpt_active <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign step_up = press[B_UP] | (rpt_fire & db_state[B_UP]);
  assign step_dn = press[B_DN] | (rpt_fire & db_state[B_DN]);
`else
  assign step_up = press[B_UP];
  assign step_dn = press[B_DN];
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BPM <= 8'(BPM_INIT);
    end else if (step_up && !step_dn && (BPM < 8'(BPM_MAX))) begin
      BPM <= BPM + 8'd1;
    end else if (step_dn && !step_up && (BPM > 8'(BPM_MIN))) begin
      BPM <= BPM - 8'd1;
    end
  end

  typedef enum logic {ST_PAUSED, ST_PLAYING} tr_state_t;

  tr_state_t   tr_state;
  logic [15:0] acc;
  logic [16:0] sum;

  assign sum  = {1'b0, acc} + {9'd0, BPM};
  assign PLAY = (tr_state == ST_PLAYING);

  // Fractional beat accumulator: adding BPM per ms and wrapping at 60000 gives an exact mean period.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tr_state <= ST_PAUSED;
      acc      <= '0;
      BEAT     <= 1'b0;
    end else begin
      case (tr_state)
        ST_PAUSED: begin
          acc <= '0;
          if (press[B_PL]) begin
            tr_state <= ST_PLAYING;
            BEAT     <= 1'b1;
          end else begin
            BEAT <= 1'b0;
          end
        end
        ST_PLAYING: begin
          if (press[B_PL]) begin
            tr_state <= ST_PAUSED;
            acc      <= '0;
            BEAT     <= 1'b0;
          end else if (tick) begin
            if (sum >= ACC_WRAP) begin
              acc  <= 16'(sum - ACC_WRAP);
              BEAT <= 1'b1;
            end else begin
              acc  <= sum[15:0];
              BEAT <= 1'b0;
            end
          end else begin
            BEAT <= 1'b0;
          end
        end
        default: begin
          tr_state <= ST_PAUSED;
          acc      <= '0;
          BEAT     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_control.sv
// Self-checking bench for bpm_control: vector table, beat-timing sequences and a
// randomized action stream scored against a button-level tempo/transport model.
module tb_bpm_control;

  localparam int TICK_DIV  = 10;
  localparam int DEB       = 3;
  localparam int RPT_DELAY = 20;
  localparam int RPT_RATE  = 5;
  localparam int BPM_MIN   = 30;
  localparam int BPM_MAX   = 240;
  localparam int BPM_INIT  = 120;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_UP = 1'b0;
  logic       BTN_DOWN = 1'b0;
  logic       BTN_PLAY = 1'b0;
  logic [7:0] BPM;
  logic       PLAY;
  logic       BEAT;

  bpm_control #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEB), .BPM_MIN(BPM_MIN), .BPM_MAX(BPM_MAX),
    .BPM_INIT(BPM_INIT), .RPT_DELAY_MS(RPT_DELAY), .RPT_RATE_MS(RPT_RATE)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_PLAY(BTN_PLAY),
    .BPM(BPM), .PLAY(PLAY), .BEAT(BEAT)
  );

  always #5 CLK = ~CLK;

  typedef enum {A_UP, A_DOWN, A_BOTH, A_PLAY, A_GLITCH, A_BOUNCE} act_t;
  typedef struct {
    act_t act;
    int   hold;
    int   exp_bpm;
    int   exp_play;
  } vec_t;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   beat_q[$];
  int   rise_cyc = -1;
  int   bad_beat = 0;
  logic play_d = 1'b0;
  logic mon_en = 1'b0;
  int   m_bpm;
  int   m_play;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (BEAT) beat_q.push_back(cyc);
      if (BEAT && !PLAY) bad_beat <= bad_beat + 1;
      if (PLAY && !play_d) rise_cyc <= cyc;
    end
    play_d <= PLAY;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(posedge CLK);
  endtask

  task automatic press(input logic up, input logic dn, input logic pl, input int hold_t, input int gap_t);
    @(negedge CLK);
    BTN_UP = up; BTN_DOWN = dn; BTN_PLAY = pl;
    wait_ticks(hold_t);
    @(negedge CLK);
    BTN_UP = 1'b0; BTN_DOWN = 1'b0; BTN_PLAY = 1'b0;
    wait_ticks(gap_t);
  endtask

  task automatic do_action(input act_t a, input int hold_t, input int gap_t);
    int sel;
    case (a)
      A_UP:    press(1'b1, 1'b0, 1'b0, hold_t, gap_t);
      A_DOWN:  press(1'b0, 1'b1, 1'b0, hold_t, gap_t);
      A_BOTH:  press(1'b1, 1'b1, 1'b0, hold_t, gap_t);
      A_PLAY:  press(1'b0, 1'b0, 1'b1, hold_t, gap_t);
      A_GLITCH: begin
        sel = $urandom_range(0, 2);
        press(sel == 0, sel == 1, sel == 2, $urandom_range(1, DEB - 1), gap_t);
      end
      A_BOUNCE: begin
        for (int i = 0; i < 8; i++) begin
          @(negedge CLK);
          BTN_UP = (i % 2 == 0);
          wait_ticks(1);
        end
        @(negedge CLK);
        BTN_UP = 1'b0;
        wait_ticks(gap_t);
      end
      default: ;
    endcase
  endtask

  // Button-level model: one clean press = one step, clamped; glitches and chords do nothing.
  task automatic model_apply(input act_t a);
    case (a)
      A_UP:    m_bpm = (m_bpm + 1 > BPM_MAX) ? BPM_MAX : m_bpm + 1;
      A_DOWN:  m_bpm = (m_bpm - 1 < BPM_MIN) ? BPM_MIN : m_bpm - 1;
      A_PLAY:  m_play = 1 - m_play;
      default: ;
    endcase
  endtask

  task automatic beat_test(input int bpm_now);
    int period;
    int n_after;
    period = (60000 / bpm_now) * TICK_DIV;
    beat_q.delete();
    do_action(A_PLAY, 4, 4);
    @(negedge CLK);
    check("play_on", int'(PLAY), 1);
    for (int k = 0; k < 4 * period + 1000 && beat_q.size() < 4; k++) @(posedge CLK);
    @(negedge CLK);
    check("beat_count", (beat_q.size() >= 4) ? 4 : beat_q.size(), 4);
    if (beat_q.size() >= 4) begin
      check("downbeat_on_rise", beat_q[0], rise_cyc);
      check("first_interval_in_range",
            int'((beat_q[1] - beat_q[0] > period - TICK_DIV) && (beat_q[1] - beat_q[0] <= period)), 1);
      check("beat_interval_2", beat_q[2] - beat_q[1], period);
      check("beat_interval_3", beat_q[3] - beat_q[2], period);
    end
    do_action(A_PLAY, 4, 4);
    @(negedge CLK);
    check("play_off", int'(PLAY), 0);
    n_after = beat_q.size();
    repeat (period + 100) @(posedge CLK);
    @(negedge CLK);
    check("no_beat_after_stop", beat_q.size(), n_after);
  endtask

  initial begin
    vec_t tbl[9];
    act_t a;
    int   held;
    int   reps;
    int   exp_rep;

    tbl[0] = '{A_UP,     10, 121, 0};
    tbl[1] = '{A_DOWN,   10, 120, 0};
    tbl[2] = '{A_BOUNCE,  0, 120, 0};
    tbl[3] = '{A_BOTH,   10, 120, 0};
    tbl[4] = '{A_GLITCH,  0, 120, 0};
    tbl[5] = '{A_UP,      4, 121, 0};
    tbl[6] = '{A_UP,      4, 122, 0};
    tbl[7] = '{A_DOWN,    4, 121, 0};
    tbl[8] = '{A_DOWN,    4, 120, 0};

    RST_N = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("reset_bpm", int'(BPM), BPM_INIT);
    check("reset_play", int'(PLAY), 0);
    check("reset_beat", int'(BEAT), 0);
    RST_N = 1'b1;
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      do_action(tbl[i].act, tbl[i].hold, 5);
      @(negedge CLK);
      check($sformatf("vec%0d_bpm", i), int'(BPM), tbl[i].exp_bpm);
      check($sformatf("vec%0d_play", i), int'(PLAY), tbl[i].exp_play);
    end

    m_bpm = BPM_INIT;
    m_play = 0;
    beat_test(m_bpm);

    for (int i = 0; i < 130; i++) begin
      do_action(A_UP, 4, 4);
      model_apply(A_UP);
    end
    @(negedge CLK);
    check("saturate_max", int'(BPM), m_bpm);

    beat_test(m_bpm);

    for (int i = 0; i < 220; i++) begin
      do_action(A_DOWN, 4, 4);
      model_apply(A_DOWN);
    end
    @(negedge CLK);
    check("saturate_min", int'(BPM), m_bpm);

    for (int i = 0; i < 40; i++) begin
      a = act_t'($urandom_range(0, 5));
      do_action(a, $urandom_range(4, 8), 5);
      model_apply(a);
      @(negedge CLK);
      check($sformatf("rand%0d_bpm", i), int'(BPM), m_bpm);
      check($sformatf("rand%0d_play", i), int'(PLAY), m_play);
    end

    if (m_play == 0) do_action(A_PLAY, 4, 4);
    @(negedge CLK);
    BTN_UP = 1'b1;
    repeat (2 * TICK_DIV + 5) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    BTN_UP = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    beat_q.delete();
    wait_ticks(10);
    @(negedge CLK);
    check("midpress_reset_bpm", int'(BPM), BPM_INIT);
    check("midpress_reset_play", int'(PLAY), 0);
    check("midpress_reset_no_beat", beat_q.size(), 0);
    check("beat_only_while_play", bad_beat, 0);

    // A 50-tick raw hold yields a 50-tick debounced hold; repeats fire strictly inside it.
    held = 50;
    @(negedge CLK);
    BTN_UP = 1'b1;
    wait_ticks(held);
    @(negedge CLK);
    BTN_UP = 1'b0;
    wait_ticks(8);
    @(negedge CLK);
`ifdef AUTO_REPEAT_EN
    reps = (held > RPT_DELAY) ? (held - 1 - RPT_DELAY) / RPT_RATE + 1 : 0;
`else
    reps = 0;
`endif
    exp_rep = BPM_INIT + 1 + reps;
    if (exp_rep > BPM_MAX) exp_rep = BPM_MAX;
    check("hold_repeat_bpm", int'(BPM), exp_rep);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
